fx_square_rebuild: RTL and testbench

- Iterative fixed-point squarer: the inverse of the team's iterative fixed-point square root.
- Takes a (root, rem) pair and rebuilds the radicand using rad = (root*root + rem) >> FBITS.
- Flags overflow, and flags inputs that cannot have come from the square root unit.
- Sits next to the square root unit in the fluid-sim pipeline. It is used for self-check and for the normalisation round-trip (rebuilding velocity magnitude from its root form).
- Uses the same start/done handshake style as the square root unit.

---
 rtl/fx_square_rebuild_if.sv | 24 ++
 rtl/fx_square_rebuild.sv | 98 +++++++++
 tb/tb_fx_square_rebuild.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/fx_square_rebuild_if.sv
// Handshake and operand/result bundle for the iterative fixed-point squarer.
// Requester drives start/root/rem; the squarer returns busy/done and the rebuilt radicand.
interface fx_square_rebuild_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] root;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] rad;
    logic             ovf;
    logic             inexact;

    modport master (
        output start, root, rem,
        input  busy, done, rad, ovf, inexact
    );

    modport slave (
        input  start, root, rem,
        output busy, done, rad, ovf, inexact
    );
endinterface

// File: rtl/fx_square_rebuild.sv
// Iterative shift-add squarer: rebuilds rad = (root*root + rem) >> FBITS in WIDTH cycles,
// flagging integer overflow and a nonzero discarded fraction.
module fx_square_rebuild #(
    parameter int WIDTH = 32,
    parameter int FBITS = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fx_square_rebuild_if.slave   sq
);
    localparam int AW    = 2 * WIDTH + 1;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q, m_d;
    logic [AW-1:0]    b_q, b_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CNT_W-1:0] i_q, i_d;
    logic [WIDTH-1:0] rad_q, rad_d;
    logic             ovf_q, ovf_d;
    logic             inexact_q, inexact_d;
    logic             done_q, done_d;
    logic [AW-1:0]    sum;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            m_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            i_q       <= '0;
            rad_q     <= '0;
            ovf_q     <= 1'b0;
            inexact_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            i_q       <= i_d;
            rad_q     <= rad_d;
            ovf_q     <= ovf_d;
            inexact_q <= inexact_d;
            done_q    <= done_d;
        end
    end

    // The last step's add is folded into the result capture, so sum feeds both paths.
    always_comb begin
        state_d   = state_q;
        m_d       = m_q;
        b_d       = b_q;
        acc_d     = acc_q;
        i_d       = i_q;
        rad_d     = rad_q;
        ovf_d     = ovf_q;
        inexact_d = inexact_q;
        done_d    = 1'b0;
        sum       = acc_q + (m_q[0] ? b_q : '0);

        unique case (state_q)
            IDLE: begin
                if (sq.start) begin
                    m_d     = sq.root;
                    b_d     = {{(AW - WIDTH){1'b0}}, sq.root};
                    acc_d   = {{(AW - WIDTH){1'b0}}, sq.rem};
                    i_d     = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = sum;
                m_d   = m_q >> 1;
                b_d   = b_q << 1;
                i_d   = i_q + CNT_W'(1);
                if (i_q == LAST) begin
                    rad_d     = sum[WIDTH+FBITS-1:FBITS];
                    ovf_d     = |sum[AW-1:WIDTH+FBITS];
                    inexact_d = |sum[FBITS-1:0];
                    done_d    = 1'b1;
                    i_d       = '0;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign sq.busy    = (state_q == CALC);
    assign sq.done    = done_q;
    assign sq.rad     = rad_q;
    assign sq.ovf     = ovf_q;
    assign sq.inexact = inexact_q;
endmodule

// File: tb/tb_fx_square_rebuild.sv
// Directed bench for fx_square_rebuild at WIDTH=32, FBITS=16, plus a square-root round-trip sweep.
module tb_fx_square_rebuild;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    fx_square_rebuild_if #(.WIDTH(32)) sq ();

    fx_square_rebuild #(.WIDTH(32), .FBITS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sq    (sq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference square root: root = floor(sqrt(R << 16)), rem = (R << 16) - root^2.
    function automatic logic [31:0] isqrt64(input logic [63:0] x);
        logic [63:0] r;
        logic [63:0] t;
        r = '0;
        for (int k = 31; k >= 0; k--) begin
            t = r | (64'd1 << k);
            if (t * t <= x) r = t;
        end
        return r[31:0];
    endfunction

    task automatic wait_done(output int n);
        n = 0;
        while (sq.done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_op(input logic [31:0] r, input logic [31:0] m, output int lat);
        @(negedge clk);
        sq.start = 1'b1;
        sq.root  = r;
        sq.rem   = m;
        @(negedge clk);
        sq.start = 1'b0;
        sq.root  = 32'hDEAD_BEEF;
        sq.rem   = 32'h1234_5678;
        wait_done(lat);
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        sq.start = 1'b0;
        sq.root  = '0;
        sq.rem   = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (sq.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b want=0", sq.busy); end
        n_cmp++; if (sq.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got=%b want=0", sq.done); end
        n_cmp++; if (sq.rad !== 32'h0) begin n_bad++; $display("FAIL reset_rad got=%h want=0", sq.rad); end
        n_cmp++; if ({sq.ovf, sq.inexact} !== 2'b00) begin n_bad++; $display("FAIL reset_flags got=%b want=00", {sq.ovf, sq.inexact}); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int lat;
        do_op(32'h0002_0000, 32'h0, lat);
        n_cmp++; if (lat !== 32) begin n_bad++; $display("FAIL basic_latency got=%0d want=32", lat); end
        n_cmp++; if (sq.rad !== 32'h0004_0000) begin n_bad++; $display("FAIL basic_rad got=%h want=00040000", sq.rad); end
        n_cmp++; if ({sq.ovf, sq.inexact} !== 2'b00) begin n_bad++; $display("FAIL basic_flags got=%b want=00", {sq.ovf, sq.inexact}); end
        @(negedge clk);
        n_cmp++; if (sq.done !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width got=%b want=0", sq.done); end
        n_cmp++; if (sq.rad !== 32'h0004_0000) begin n_bad++; $display("FAIL rad_hold got=%h want=00040000", sq.rad); end
        do_op(32'h0001_8000, 32'h0, lat);
        n_cmp++; if (sq.rad !== 32'h0002_4000) begin n_bad++; $display("FAIL one_point_five_rad got=%h want=00024000", sq.rad); end
    endtask

    task automatic test_sqrt2_busy();
        int n;
        int busy_cnt;
        @(negedge clk);
        sq.start = 1'b1;
        sq.root  = 32'h0001_6A09;
        sq.rem   = 32'h0002_8BAF;
        @(negedge clk);
        sq.start = 1'b0;
        n = 0;
        busy_cnt = 0;
        while (sq.done !== 1'b1 && n < 100) begin
            if (sq.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            n++;
        end
        n_cmp++; if (busy_cnt !== 32) begin n_bad++; $display("FAIL sqrt2_busy_cycles got=%0d want=32", busy_cnt); end
        n_cmp++; if (sq.busy !== 1'b0) begin n_bad++; $display("FAIL sqrt2_busy_at_done got=%b want=0", sq.busy); end
        n_cmp++; if (sq.rad !== 32'h0002_0000) begin n_bad++; $display("FAIL sqrt2_rad got=%h want=00020000", sq.rad); end
        n_cmp++; if ({sq.ovf, sq.inexact} !== 2'b00) begin n_bad++; $display("FAIL sqrt2_flags got=%b want=00", {sq.ovf, sq.inexact}); end
    endtask

    task automatic test_inexact();
        int lat;
        do_op(32'h0000_0001, 32'h0, lat);
        n_cmp++; if (sq.rad !== 32'h0) begin n_bad++; $display("FAIL tiny_rad got=%h want=0", sq.rad); end
        n_cmp++; if ({sq.ovf, sq.inexact} !== 2'b01) begin n_bad++; $display("FAIL tiny_flags got=%b want=01", {sq.ovf, sq.inexact}); end
    endtask

    task automatic test_overflow();
        int lat;
        // (2^32-1)^2 + (2^32-1) = 0xFFFFFFFF_00000000
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        n_cmp++; if (sq.rad !== 32'hFFFF_0000) begin n_bad++; $display("FAIL ovf_rad got=%h want=ffff0000", sq.rad); end
        n_cmp++; if ({sq.ovf, sq.inexact} !== 2'b10) begin n_bad++; $display("FAIL ovf_flags got=%b want=10", {sq.ovf, sq.inexact}); end
        // (2^32-1)^2 = 0xFFFFFFFE_00000001
        do_op(32'hFFFF_FFFF, 32'h0, lat);
        n_cmp++; if (sq.rad !== 32'hFFFE_0000) begin n_bad++; $display("FAIL ovf2_rad got=%h want=fffe0000", sq.rad); end
        n_cmp++; if ({sq.ovf, sq.inexact} !== 2'b11) begin n_bad++; $display("FAIL ovf2_flags got=%b want=11", {sq.ovf, sq.inexact}); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        sq.start = 1'b1;
        sq.root  = 32'h0002_0000;
        sq.rem   = 32'h0;
        @(negedge clk);
        sq.root  = 32'h0003_0000;
        wait_done(n);
        n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL b2b_first_latency got=%0d want=32", n); end
        n_cmp++; if (sq.rad !== 32'h0004_0000) begin n_bad++; $display("FAIL b2b_first_rad got=%h want=00040000", sq.rad); end
        sq.root = 32'h0001_8000;
        @(negedge clk);
        n_cmp++; if ({sq.busy, sq.done} !== 2'b10) begin n_bad++; $display("FAIL b2b_accept_in_done got=%b want=10", {sq.busy, sq.done}); end
        sq.root = 32'h0001_0000;
        wait_done(n);
        n_cmp++; if (n !== 32) begin n_bad++; $display("FAIL b2b_second_latency got=%0d want=32", n); end
        n_cmp++; if (sq.rad !== 32'h0002_4000) begin n_bad++; $display("FAIL b2b_second_rad got=%h want=00024000", sq.rad); end
        sq.start = 1'b0;
        @(negedge clk);
        n_cmp++; if ({sq.busy, sq.done} !== 2'b00) begin n_bad++; $display("FAIL b2b_idle_after got=%b want=00", {sq.busy, sq.done}); end
    endtask

    task automatic test_reset_abort();
        int seen;
        @(negedge clk);
        sq.start = 1'b1;
        sq.root  = 32'h0002_0000;
        sq.rem   = 32'h0;
        @(negedge clk);
        sq.start = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_cmp++; if (sq.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy got=%b want=0", sq.busy); end
        n_cmp++; if ({sq.rad, sq.ovf, sq.inexact} !== 34'h0) begin n_bad++; $display("FAIL abort_outputs got=%h want=0", {sq.rad, sq.ovf, sq.inexact}); end
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (sq.done === 1'b1 || sq.busy === 1'b1) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL abort_no_done got=%0d want=0", seen); end
        n_cmp++; if (sq.rad !== 32'h0) begin n_bad++; $display("FAIL abort_rad_stays got=%h want=0", sq.rad); end
    endtask

    task automatic test_round_trip();
        logic [31:0] r_list [10];
        logic [63:0] x;
        logic [31:0] root;
        logic [63:0] rem64;
        int          lat;
        r_list[0] = 32'h0;
        r_list[1] = 32'hFFFF_FFFF;
        r_list[2] = 32'h0000_0001;
        r_list[3] = 32'h0003_0000;
        for (int k = 4; k < 10; k++) r_list[k] = $urandom;
        for (int k = 0; k < 10; k++) begin
            x     = {16'h0, r_list[k], 16'h0};
            root  = isqrt64(x);
            rem64 = x - {32'h0, root} * {32'h0, root};
            do_op(root, rem64[31:0], lat);
            n_cmp++;
            if (lat !== 32 || sq.rad !== r_list[k] || sq.ovf !== 1'b0 || sq.inexact !== 1'b0) begin
                n_bad++;
                $display("FAIL round_trip R=%h root=%h rem=%h got rad=%h ovf=%b inexact=%b lat=%0d want rad=%h ovf=0 inexact=0 lat=32",
                         r_list[k], root, rem64[31:0], sq.rad, sq.ovf, sq.inexact, lat, r_list[k]);
            end
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_basic();
        test_sqrt2_busy();
        test_inexact();
        test_overflow();
        test_back_to_back();
        test_reset_abort();
        test_round_trip();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
